// File: rtl/radix2_div_pkg.sv
// Shared definitions for the radix-2 restoring divider: FSM states and default width.
// Result layout: c = {remainder, quotient}; the remainder occupies the upper WIDTH bits.
package radix2_div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/radix2_div_if.sv
// Request/response bundle for radix2_div; the requester uses master, the divider uses slave.
interface radix2_div_if
    import radix2_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);

    logic               in_valid;
    logic               in_ready;
    logic               is_signed;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] c;
    logic               div_by_zero;

    modport master (
        output in_valid, is_signed, a, b, flush, out_ready,
        input  in_ready, out_valid, c, div_by_zero
    );

    modport slave (
        input  in_valid, is_signed, a, b, flush, out_ready,
        output in_ready, out_valid, c, div_by_zero
    );

endinterface

// File: rtl/radix2_div_step.sv
// One restoring division step: shift {rem, quo} left, subtract divisor when it fits.
module div_step
    import radix2_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] partial;

    // The shifted remainder needs one extra bit when the divisor exceeds 2^(WIDTH-1).
    always_comb begin
        partial  = {rem, quo[WIDTH-1]};
        rem_next = partial[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], 1'b0};
        if (partial >= {1'b0, divisor}) begin
            rem_next = partial[WIDTH-1:0] - divisor;
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/radix2_div.sv
// Iterative radix-2 restoring divider, signed/unsigned, one quotient bit per cycle.
module radix2_div
    import radix2_div_pkg::*;
#(
    parameter int WIDTH      = DIV_WIDTH,
    parameter int EARLY_ZERO = 1
) (
    input logic         clk,
    input logic         reset,
    radix2_div_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);

    div_state_t       state, state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem, quo, divisor, a_orig;
    logic             q_neg, r_neg, zero_div;
    logic [2*WIDTH-1:0] c_reg;
    logic             dz_reg;
    logic             accept, early, last_step;
    logic [WIDTH-1:0] a_mag, b_mag, rem_step, quo_step, rem_fix, quo_fix;

    assign accept    = bus.in_valid && (state == IDLE) && !bus.flush;
    assign early     = (EARLY_ZERO != 0) && ((bus.a == '0) || (bus.b == '0));
    assign last_step = (cnt == CW'(WIDTH - 1));
    assign a_mag     = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign b_mag     = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    assign rem_fix   = r_neg ? -rem_step : rem_step;
    assign quo_fix   = q_neg ? -quo_step : quo_step;

    assign bus.in_ready    = (state == IDLE);
    assign bus.out_valid   = (state == DONE);
    assign bus.c           = c_reg;
    assign bus.div_by_zero = dz_reg;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (divisor),
        .rem_next (rem_step),
        .quo_next (quo_step)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Flush overrides every transition, including accept and the output handshake.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = early ? DONE : CALC;
            CALC:    if (last_step) state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (bus.flush) state_next = IDLE;
    end

    // Divide-by-zero reports the original dividend, so it bypasses sign correction.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            divisor  <= '0;
            a_orig   <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            zero_div <= 1'b0;
            c_reg    <= '0;
            dz_reg   <= 1'b0;
        end else if (accept) begin
            cnt      <= '0;
            rem      <= '0;
            quo      <= a_mag;
            divisor  <= b_mag;
            a_orig   <= bus.a;
            q_neg    <= bus.is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            r_neg    <= bus.is_signed && bus.a[WIDTH-1];
            zero_div <= (bus.b == '0);
            if (early) begin
                c_reg  <= (bus.b == '0) ? {bus.a, {WIDTH{1'b1}}} : '0;
                dz_reg <= (bus.b == '0);
            end
        end else if ((state == CALC) && !bus.flush) begin
            rem <= rem_step;
            quo <= quo_step;
            cnt <= cnt + CW'(1);
            if (last_step) begin
                c_reg  <= zero_div ? {a_orig, {WIDTH{1'b1}}} : {rem_fix, quo_fix};
                dz_reg <= zero_div;
            end
        end
    end

endmodule

// File: tb/tb_radix2_div.sv
// Scoreboard bench for radix2_div: 32-bit early-zero, 32-bit iterating and 16-bit instances.
module tb_radix2_div;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  sel = 2'd0;
    logic        tb_valid = 1'b0;
    logic        tb_signed = 1'b0;
    logic        tb_flush = 1'b0;
    logic        tb_oready = 1'b1;
    logic [31:0] tb_a = '0;
    logic [31:0] tb_b = '0;

    logic        obs_ready, obs_valid, obs_dz;
    logic [31:0] obs_q, obs_r;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    radix2_div_if #(.WIDTH(32)) bus0 ();
    radix2_div_if #(.WIDTH(32)) bus_nez ();
    radix2_div_if #(.WIDTH(16)) bus16 ();

    assign bus0.in_valid    = tb_valid && (sel == 2'd0);
    assign bus0.is_signed   = tb_signed;
    assign bus0.a           = tb_a;
    assign bus0.b           = tb_b;
    assign bus0.flush       = tb_flush;
    assign bus0.out_ready   = tb_oready;
    assign bus_nez.in_valid  = tb_valid && (sel == 2'd1);
    assign bus_nez.is_signed = tb_signed;
    assign bus_nez.a         = tb_a;
    assign bus_nez.b         = tb_b;
    assign bus_nez.flush     = tb_flush;
    assign bus_nez.out_ready = tb_oready;
    assign bus16.in_valid   = tb_valid && (sel == 2'd2);
    assign bus16.is_signed  = tb_signed;
    assign bus16.a          = tb_a[15:0];
    assign bus16.b          = tb_b[15:0];
    assign bus16.flush      = tb_flush;
    assign bus16.out_ready  = tb_oready;

    radix2_div #(.WIDTH(32), .EARLY_ZERO(1)) u_dut (.clk(clk), .reset(reset), .bus(bus0));
    radix2_div #(.WIDTH(32), .EARLY_ZERO(0)) u_dut_nez (.clk(clk), .reset(reset), .bus(bus_nez));
    radix2_div #(.WIDTH(16), .EARLY_ZERO(1)) u_dut16 (.clk(clk), .reset(reset), .bus(bus16));

    always #5 clk = ~clk;

    always_comb begin
        obs_ready = bus0.in_ready;
        obs_valid = bus0.out_valid;
        obs_dz    = bus0.div_by_zero;
        obs_q     = bus0.c[31:0];
        obs_r     = bus0.c[63:32];
        case (sel)
            2'd1: begin
                obs_ready = bus_nez.in_ready;
                obs_valid = bus_nez.out_valid;
                obs_dz    = bus_nez.div_by_zero;
                obs_q     = bus_nez.c[31:0];
                obs_r     = bus_nez.c[63:32];
            end
            2'd2: begin
                obs_ready = bus16.in_ready;
                obs_valid = bus16.out_valid;
                obs_dz    = bus16.div_by_zero;
                obs_q     = {16'h0, bus16.c[15:0]};
                obs_r     = {16'h0, bus16.c[31:16]};
            end
            default: ;
        endcase
    end

    // Reference divides magnitudes with the simulator's own operators, then restores signs.
    function automatic exp_t model(input logic [31:0] av_in, input logic [31:0] bv_in,
                                   input bit sg, input int w, input bit ez);
        exp_t        e;
        logic [31:0] mask, av, bv, ma, mb;
        bit          an, bn;
        mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        av = av_in & mask;
        bv = bv_in & mask;
        an = sg && av[w-1];
        bn = sg && bv[w-1];
        ma = an ? ((-av) & mask) : av;
        mb = bn ? ((-bv) & mask) : bv;
        if (bv == 0) begin
            e.q = mask;
            e.r = av;
            e.dz = 1'b1;
        end else begin
            e.q = ma / mb;
            e.r = ma % mb;
            if (an ^ bn) e.q = (-e.q) & mask;
            if (an) e.r = (-e.r) & mask;
            e.dz = 1'b0;
        end
        e.lat = (ez && (av == 0 || bv == 0)) ? 1 : w + 1;
        return e;
    endfunction

    task automatic send(input logic [31:0] av, input logic [31:0] bv, input bit sg);
        int w;
        int n;
        w = (sel == 2'd2) ? 16 : 32;
        exp_q.push_back(model(av, bv, sg, w, sel != 2'd1));
        @(negedge clk);
        tb_a = av;
        tb_b = bv;
        tb_signed = sg;
        tb_valid = 1'b1;
        n = 0;
        while (!obs_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        tb_valid = 1'b0;
        tb_a = $urandom;
        tb_b = $urandom;
        tb_signed = 1'($urandom);
    endtask

    task automatic wait_result(output int lat);
        lat = 1;
        @(negedge clk);
        while (!obs_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            @(negedge clk);
            n_checks++;
            if (obs_ready !== 1'b1 || obs_valid !== 1'b0 || obs_q !== 32'h0 || obs_r !== 32'h0 || obs_dz !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL reset_hold dut%0d: got rdy=%b vld=%b q=%h r=%h dz=%b, expected rdy=1 vld=0 q=0 r=0 dz=0",
                         s, obs_ready, obs_valid, obs_q, obs_r, obs_dz);
            end
        end
        sel = 2'd0;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs_ready !== 1'b1 || obs_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_release: got rdy=%b vld=%b, expected rdy=1 vld=0", obs_ready, obs_valid);
        end
    endtask

    task automatic test_basic;
        logic [31:0] ta[4] = '{32'd100, 32'd5, 32'd0, 32'hFFFF_FFFF};
        logic [31:0] tbv[4] = '{32'd7, 32'd9, 32'd5, 32'h8000_0000};
        int   lat;
        exp_t e;
        sel = 2'd0;
        for (int i = 0; i < 4; i++) begin
            send(ta[i], tbv[i], 1'b0);
            wait_result(lat);
            e = exp_q.pop_front();
            n_checks++;
            if (!obs_valid || lat != e.lat || obs_q !== e.q || obs_r !== e.r || obs_dz !== e.dz) begin
                n_fail++;
                $display("[TB] FAIL basic_%0d: got q=%h r=%h dz=%b lat=%0d, expected q=%h r=%h dz=%b lat=%0d",
                         i, obs_q, obs_r, obs_dz, lat, e.q, e.r, e.dz, e.lat);
            end
        end
    endtask

    task automatic test_signed;
        logic [31:0] ta[4] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FF9C};
        logic [31:0] tbv[4] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
        int   lat;
        exp_t e;
        sel = 2'd0;
        for (int i = 0; i < 4; i++) begin
            send(ta[i], tbv[i], 1'b1);
            wait_result(lat);
            e = exp_q.pop_front();
            n_checks++;
            if (!obs_valid || lat != e.lat || obs_q !== e.q || obs_r !== e.r || obs_dz !== e.dz) begin
                n_fail++;
                $display("[TB] FAIL signed_%0d: got q=%h r=%h dz=%b lat=%0d, expected q=%h r=%h dz=%b lat=%0d",
                         i, obs_q, obs_r, obs_dz, lat, e.q, e.r, e.dz, e.lat);
            end
        end
    endtask

    task automatic test_div_zero;
        logic [31:0] ta[3] = '{32'd5, 32'hFFFF_FFFB, 32'd0};
        bit          tsg[3] = '{1'b0, 1'b1, 1'b1};
        int   lat;
        exp_t e;
        for (int s = 0; s < 2; s++) begin
            sel = 2'(s);
            for (int i = 0; i < 3; i++) begin
                send(ta[i], 32'd0, tsg[i]);
                wait_result(lat);
                e = exp_q.pop_front();
                n_checks++;
                if (!obs_valid || lat != e.lat || obs_q !== e.q || obs_r !== e.r || obs_dz !== e.dz) begin
                    n_fail++;
                    $display("[TB] FAIL div_zero_dut%0d_%0d: got q=%h r=%h dz=%b lat=%0d, expected q=%h r=%h dz=%b lat=%0d",
                             s, i, obs_q, obs_r, obs_dz, lat, e.q, e.r, e.dz, e.lat);
                end
            end
        end
        sel = 2'd0;
    endtask

    task automatic test_stall;
        int   lat;
        exp_t e;
        sel = 2'd0;
        tb_oready = 1'b0;
        send(32'd100, 32'd7, 1'b0);
        wait_result(lat);
        e = exp_q.pop_front();
        n_checks++;
        if (!obs_valid || lat != e.lat || obs_q !== e.q || obs_r !== e.r) begin
            n_fail++;
            $display("[TB] FAIL stall_first: got q=%h r=%h lat=%0d, expected q=%h r=%h lat=%0d",
                     obs_q, obs_r, lat, e.q, e.r, e.lat);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            tb_valid = 1'b1;
            tb_a = $urandom;
            tb_b = $urandom;
            @(negedge clk);
            n_checks++;
            if (obs_valid !== 1'b1 || obs_ready !== 1'b0 || obs_q !== e.q || obs_r !== e.r) begin
                n_fail++;
                $display("[TB] FAIL stall_hold_%0d: got vld=%b rdy=%b q=%h r=%h, expected vld=1 rdy=0 q=%h r=%h",
                         i, obs_valid, obs_ready, obs_q, obs_r, e.q, e.r);
            end
        end
        tb_a = 32'd9;
        tb_b = 32'd3;
        tb_oready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tb_valid = 1'b0;
        n_checks++;
        if (obs_valid !== 1'b0 || obs_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL stall_release: got vld=%b rdy=%b, expected vld=0 rdy=1", obs_valid, obs_ready);
        end
    endtask

    task automatic test_flush;
        int   lat;
        exp_t e;
        sel = 2'd0;
        send(32'd100, 32'd7, 1'b0);
        repeat (10) @(negedge clk);
        tb_flush = 1'b1;
        @(posedge clk);
        #1;
        tb_flush = 1'b0;
        void'(exp_q.pop_front());
        @(negedge clk);
        n_checks++;
        if (obs_valid !== 1'b0 || obs_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL flush_calc: got vld=%b rdy=%b, expected vld=0 rdy=1", obs_valid, obs_ready);
        end
        send(32'd9, 32'd3, 1'b0);
        wait_result(lat);
        e = exp_q.pop_front();
        n_checks++;
        if (!obs_valid || lat != e.lat || obs_q !== e.q || obs_r !== e.r || obs_dz !== e.dz) begin
            n_fail++;
            $display("[TB] FAIL flush_next: got q=%h r=%h dz=%b lat=%0d, expected q=%h r=%h dz=%b lat=%0d",
                     obs_q, obs_r, obs_dz, lat, e.q, e.r, e.dz, e.lat);
        end
        @(negedge clk);
        tb_a = 32'd9;
        tb_b = 32'd3;
        tb_valid = 1'b1;
        tb_flush = 1'b1;
        @(posedge clk);
        #1;
        tb_valid = 1'b0;
        tb_flush = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs_ready !== 1'b1 || obs_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL flush_vs_accept: got rdy=%b vld=%b, expected rdy=1 vld=0", obs_ready, obs_valid);
        end
        tb_oready = 1'b0;
        send(32'd9, 32'd3, 1'b0);
        wait_result(lat);
        void'(exp_q.pop_front());
        tb_flush = 1'b1;
        @(posedge clk);
        #1;
        tb_flush = 1'b0;
        tb_oready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (obs_valid !== 1'b0 || obs_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL flush_done: got vld=%b rdy=%b, expected vld=0 rdy=1", obs_valid, obs_ready);
        end
    endtask

    task automatic test_reset_mid;
        int   lat;
        int   stray;
        sel = 2'd0;
        send(32'd100, 32'd7, 1'b0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        void'(exp_q.pop_front());
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (obs_valid !== 1'b0 || obs_ready !== 1'b1) stray++;
        end
        n_checks++;
        if (stray != 0) begin
            n_fail++;
            $display("[TB] FAIL reset_calc: got %0d cycles with vld=1 or rdy=0, expected 0", stray);
        end
        tb_oready = 1'b0;
        send(32'd100, 32'd7, 1'b0);
        wait_result(lat);
        void'(exp_q.pop_front());
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        tb_oready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (obs_valid !== 1'b0 || obs_ready !== 1'b1 || obs_q !== 32'h0 || obs_r !== 32'h0 || obs_dz !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_done: got vld=%b rdy=%b q=%h r=%h dz=%b, expected vld=0 rdy=1 q=0 r=0 dz=0",
                     obs_valid, obs_ready, obs_q, obs_r, obs_dz);
        end
    endtask

    task automatic test_random(input logic [1:0] which, input int count);
        logic [31:0] av, bv;
        bit   sg;
        int   lat;
        exp_t e;
        sel = which;
        for (int i = 0; i < count; i++) begin
            sg = 1'($urandom_range(0, 1));
            av = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 30)) : $urandom;
            case ($urandom_range(0, 7))
                0:       bv = 32'd0;
                1:       bv = 32'($urandom_range(1, 9));
                2:       bv = 32'hFFFF_FFFF;
                default: bv = $urandom;
            endcase
            send(av, bv, sg);
            wait_result(lat);
            e = exp_q.pop_front();
            n_checks++;
            if (!obs_valid || lat != e.lat || obs_q !== e.q || obs_r !== e.r || obs_dz !== e.dz) begin
                n_fail++;
                $display("[TB] FAIL random_dut%0d a=%h b=%h s=%b: got q=%h r=%h dz=%b lat=%0d, expected q=%h r=%h dz=%b lat=%0d",
                         which, av, bv, sg, obs_q, obs_r, obs_dz, lat, e.q, e.r, e.dz, e.lat);
            end
        end
        sel = 2'd0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_div_zero();
        test_stall();
        test_flush();
        test_reset_mid();
        test_random(2'd0, 400);
        test_random(2'd2, 400);
        test_random(2'd1, 100);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
